// File: rtl/ana_spi_rx.sv
// Receive endpoint of the pseudo-SPI analog configuration link: oversamples the
// two-phase serial clocks, assembles a configuration word and commits it on LAT.
module ana_spi_rx #(
    parameter int SHIFT_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SCLK1,
    input  logic                 SCLK2,
    input  logic                 LAT,
    input  logic                 SI,
    output logic                 SO,
    output logic [SHIFT_LEN-1:0] CFG_Q,
    output logic                 CFG_VLD,
    output logic [CNT_W-1:0]     BIT_CNT,
    output logic                 BUSY,
    output logic                 PH_ERR,
    output logic                 OV_ERR,
    output logic                 LEN_ERR
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SHIFT_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SHIFT_LEN + 1);

    // Synchronizer bit order: {SI, LAT, SCLK2, SCLK1}; s3 only covers the clocks.
    logic [3:0] s1_q;
    logic [3:0] s2_q;
    logic [2:0] s3_q;

    logic                 hold_q,    hold_d;
    logic                 pend_q,    pend_d;
    logic [SHIFT_LEN-1:0] sr_q,      sr_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [SHIFT_LEN-1:0] cfgWord_q, cfgWord_d;
    logic                 vld_q,     vld_d;
    logic                 phErr_q,   phErr_d;
    logic                 ovErr_q,   ovErr_d;
    logic                 lenErr_q,  lenErr_d;

    logic rise1, rise2, riseLat, siSync;

    assign rise1   = s2_q[0] & ~s3_q[0];
    assign rise2   = s2_q[1] & ~s3_q[1];
    assign riseLat = s2_q[2] & ~s3_q[2];
    assign siSync  = s2_q[3];

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {SI, LAT, SCLK2, SCLK1};
            s2_q <= s1_q;
            s3_q <= s2_q[2:0];
        end
    end

    // Shift first, then evaluate LAT on the updated count so a coincident last bit is committed.
    always_comb begin
        hold_d    = hold_q;
        pend_d    = pend_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        cfgWord_d = cfgWord_q;
        vld_d     = 1'b0;
        phErr_d   = phErr_q;
        ovErr_d   = ovErr_q;
        lenErr_d  = lenErr_q;

        if (rise1 && rise2) begin
            ovErr_d = 1'b1;
        end else if (rise1) begin
            hold_d = siSync;
            pend_d = 1'b1;
        end else if (rise2) begin
            if (pend_q) begin
                sr_d   = {sr_q[SHIFT_LEN-2:0], hold_q};
                pend_d = 1'b0;
                cnt_d  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
            end else begin
                phErr_d = 1'b1;
            end
        end

        if (riseLat) begin
            if (cnt_d == CNT_FULL) begin
                cfgWord_d = sr_d;
                vld_d     = 1'b1;
            end else begin
                lenErr_d = 1'b1;
            end
            cnt_d  = '0;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_q    <= 1'b0;
            pend_q    <= 1'b0;
            sr_q      <= '0;
            cnt_q     <= '0;
            cfgWord_q <= '0;
            vld_q     <= 1'b0;
            phErr_q   <= 1'b0;
            ovErr_q   <= 1'b0;
            lenErr_q  <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            pend_q    <= pend_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            cfgWord_q <= cfgWord_d;
            vld_q     <= vld_d;
            phErr_q   <= phErr_d;
            ovErr_q   <= ovErr_d;
            lenErr_q  <= lenErr_d;
        end
    end

    assign SO      = sr_q[SHIFT_LEN-1];
    assign CFG_Q   = cfgWord_q;
    assign CFG_VLD = vld_q;
    assign BIT_CNT = cnt_q;
    assign BUSY    = (cnt_q != '0);
    assign PH_ERR  = phErr_q;
    assign OV_ERR  = ovErr_q;
    assign LEN_ERR = lenErr_q;

endmodule

// File: tb/tb_ana_spi_rx.sv
// Directed bench for ana_spi_rx: a reference model tracks the shift register and flags,
// and committed words are checked against a scoreboard queue when CFG_VLD pulses.
module tb_ana_spi_rx;

    localparam int SL = 16;
    localparam int CW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          SCLK1 = 1'b0, SCLK2 = 1'b0, LAT = 1'b0, SI = 1'b0;
    logic          SO;
    logic [SL-1:0] CFG_Q;
    logic          CFG_VLD;
    logic [CW-1:0] BIT_CNT;
    logic          BUSY, PH_ERR, OV_ERR, LEN_ERR;

    int checks = 0;
    int errors = 0;
    int commitsSeen = 0;
    int commitsExpected = 0;

    logic [SL-1:0] sbQ[$];
    logic [SL-1:0] modelSr = '0;
    logic [SL-1:0] expCfg = '0;
    int            modelCnt = 0;
    logic          expPh = 1'b0, expOv = 1'b0, expLen = 1'b0;
    logic          prevVld = 1'b0;

    ana_spi_rx #(.SHIFT_LEN(SL), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .SCLK1(SCLK1), .SCLK2(SCLK2), .LAT(LAT), .SI(SI),
        .SO(SO), .CFG_Q(CFG_Q), .CFG_VLD(CFG_VLD), .BIT_CNT(BIT_CNT), .BUSY(BUSY),
        .PH_ERR(PH_ERR), .OV_ERR(OV_ERR), .LEN_ERR(LEN_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".cfg"}, 32'(CFG_Q), 32'(expCfg));
        checkOutput({tag, ".cnt"}, 32'(BIT_CNT), 32'(modelCnt));
        checkOutput({tag, ".busy"}, 32'(BUSY), 32'(modelCnt != 0));
        checkOutput({tag, ".so"}, 32'(SO), 32'(modelSr[SL-1]));
        checkOutput({tag, ".ph"}, 32'(PH_ERR), 32'(expPh));
        checkOutput({tag, ".ov"}, 32'(OV_ERR), 32'(expOv));
        checkOutput({tag, ".len"}, 32'(LEN_ERR), 32'(expLen));
    endtask

    task automatic modelShift(input logic b);
        modelSr = {modelSr[SL-2:0], b};
        if (modelCnt < SL + 1) modelCnt++;
    endtask

    task automatic modelLat();
        if (modelCnt == SL) begin
            expCfg = modelSr;
            sbQ.push_back(modelSr);
            commitsExpected++;
        end else begin
            expLen = 1'b1;
        end
        modelCnt = 0;
    endtask

    task automatic applyStimulus(input logic b, input logic withLat);
        SI = b;
        waitCycles(3);
        SCLK1 = 1'b1;
        waitCycles(2);
        SCLK1 = 1'b0;
        SCLK2 = 1'b1;
        LAT   = withLat;
        modelShift(b);
        if (withLat) modelLat();
        waitCycles(2);
        SCLK2 = 1'b0;
        LAT   = 1'b0;
        waitCycles(withLat ? 4 : 1);
    endtask

    task automatic sendWord(input logic [31:0] v, input int n, input logic checkEach);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(v[i], 1'b0);
            if (checkEach) begin
                checkOutput("bit.so", 32'(SO), 32'(modelSr[SL-1]));
                checkOutput("bit.cnt", 32'(BIT_CNT), 32'(modelCnt));
            end
        end
    endtask

    task automatic pulseLat();
        waitCycles(1);
        LAT = 1'b1;
        modelLat();
        waitCycles(2);
        LAT = 1'b0;
        waitCycles(4);
    endtask

    task automatic pulseSclk2Alone();
        SCLK2 = 1'b1;
        waitCycles(2);
        SCLK2 = 1'b0;
        waitCycles(4);
    endtask

    task automatic clearModel();
        modelSr = '0; expCfg = '0; modelCnt = 0;
        expPh = 1'b0; expOv = 1'b0; expLen = 1'b0;
    endtask

    // Every CFG_VLD pulse must be a single cycle and match the oldest queued commit.
    always @(negedge CLK) begin
        if (CFG_VLD) begin
            commitsSeen++;
            if (prevVld) begin
                checkOutput("vld_width", 32'd2, 32'd1);
            end else if (sbQ.size() == 0) begin
                checkOutput("vld_unexpected", 32'(CFG_Q), 32'hFFFF_FFFF);
            end else begin
                checkOutput("commit_word", 32'(CFG_Q), 32'(sbQ.pop_front()));
            end
        end
        prevVld = CFG_VLD;
    end

    initial begin
        $display("[TB] start");
        SCLK1 = 1'b1; SCLK2 = 1'b1; LAT = 1'b1; SI = 1'b1;
        waitCycles(2);
        checkState("reset_all_high");

        // Leave only SCLK1 high across reset exit: exactly one SCLK1 rise must appear.
        SCLK2 = 1'b0; LAT = 1'b0;
        waitCycles(1);
        RST = 1'b0;
        waitCycles(4);
        checkState("reset_exit_pending");
        pulseSclk2Alone();
        modelShift(1'b1);
        checkState("reset_exit_shift");
        SCLK1 = 1'b0;
        waitCycles(2);
        pulseLat();
        checkState("reset_exit_lat");

        RST = 1'b1; SCLK1 = 1'b0; SI = 1'b0;
        waitCycles(2);
        RST = 1'b0;
        clearModel();
        waitCycles(2);
        checkState("reset2");

        sendWord(32'hA5C3, SL, 1'b1);
        pulseLat();
        checkState("nominal");

        sendWord(32'h1234, SL - 1, 1'b0);
        pulseLat();
        checkState("short_word");
        sendWord(32'hABCDE, 20, 1'b0);
        checkState("long_saturated");
        pulseLat();
        checkState("long_lat");

        pulseSclk2Alone();
        expPh = 1'b1;
        checkState("phase_err");
        sendWord(32'h3C5A, SL, 1'b0);
        pulseLat();
        checkState("after_phase_err");

        SCLK1 = 1'b1; SCLK2 = 1'b1;
        waitCycles(2);
        SCLK1 = 1'b0; SCLK2 = 1'b0;
        waitCycles(4);
        expOv = 1'b1;
        checkState("overlap");

        sendWord(32'h7807, SL - 1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkState("lat_with_bit16");

        sendWord(32'h1FF, 9, 1'b0);
        checkState("mid_word");
        RST = 1'b1;
        waitCycles(1);
        RST = 1'b0;
        clearModel();
        waitCycles(2);
        checkState("mid_word_reset");
        sendWord(32'h0001, SL, 1'b0);
        pulseLat();
        checkState("after_mid_reset");

        waitCycles(4);
        checkOutput("queue_empty", 32'(sbQ.size()), 32'd0);
        checkOutput("commit_count", 32'(commitsSeen), 32'(commitsExpected));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ana_spi_rx.md
# ana_spi_rx

Receive-side endpoint of the pseudo-SPI analog configuration link. Oversamples the two-phase serial clocks (SCLK1/SCLK2), latch strobe (LAT) and serial data from the CPU-side SPI transmitter in the system CLK domain. Assembles a SHIFT_LEN-bit configuration word and commits it to a parallel output register on LAT. Exposes a shift-out bit for daisy-chaining/readback, and flags protocol errors (phase order, overlap, length).

## Interface
Parameters:
- SHIFT_LEN, 16, bits per configuration word (≥2)
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > SHIFT_LEN+1

Ports:
- CLK  in  1  system clock, rising edge; all SCLK1/SCLK2/LAT/SI are asynchronous to it
- RST  in  1  synchronous, active-high reset
- SCLK1  in  1  phase-1 serial clock; rising edge samples SI
- SCLK2  in  1  phase-2 serial clock; rising edge shifts sampled bit in
- LAT  in  1  latch strobe; rising edge commits word
- SI  in  1  serial data, MSB first
- SO  out  1  MSB of shift register (chain/readback bit)
- CFG_Q  out  SHIFT_LEN  committed configuration word
- CFG_VLD  out  1  one-cycle pulse on successful commit
- BIT_CNT  out  CNT_W  bits shifted since last LAT (saturating)
- BUSY  out  1  BIT_CNT != 0
- PH_ERR  out  1  sticky: SCLK2 rise without pending SCLK1 sample
- OV_ERR  out  1  sticky: SCLK1 and SCLK2 rise detected in same cycle
- LEN_ERR  out  1  sticky: LAT with BIT_CNT != SHIFT_LEN

## Operation
- Synchronizers: SCLK1, SCLK2, LAT, SI each pass through 2 flops (s1,s2), plus a delay flop (s3) on the three clocks. Rise = s2 & !s3.
- Internal state: hold bit H, pending flag P, shift register SR[SHIFT_LEN-1:0], BIT_CNT, CFG_Q, error flags.
- SCLK1 rise (alone): H <= synced SI; P <= 1. A second SCLK1 rise before SCLK2 overwrites H; no error.
- SCLK2 rise (alone), P=1: SR <= {SR[SHIFT_LEN-2:0], H}; P <= 0; BIT_CNT <= min(BIT_CNT+1, SHIFT_LEN+1).
- SCLK2 rise (alone), P=0: no shift; PH_ERR <= 1.
- SCLK1 and SCLK2 rise in same cycle: neither acts; OV_ERR <= 1.
- LAT rise with BIT_CNT == SHIFT_LEN: CFG_Q <= SR; CFG_VLD <= 1 for one cycle.
- LAT rise with BIT_CNT != SHIFT_LEN (includes 0 and saturated overflow): CFG_Q unchanged; LEN_ERR <= 1.
- Every LAT rise: BIT_CNT <= 0; P <= 0. SR is retained, so SO still presents the last word's MSB.
- LAT rise coincident with SCLK2 rise: the shift is applied first and counted, then the LAT rule is evaluated on the updated count. The same cycle's commit includes the new bit.
- SO = SR[SHIFT_LEN-1], combinational from SR.
- Error flags clear only on RST.
- RST: all synchronizer flops, H, P, SR, BIT_CNT, CFG_Q, CFG_VLD, and error flags go to 0. Hence SO=0 and BUSY=0. A reset mid-word discards the partial word; post-reset edges are detected only after the inputs are resampled, so a level-high input at reset exit produces one rise.

## Timing
- Input high first sampled at CLK edge k → s2=1 after edge k+1 → action registered at edge k+2.
- Latency from input edge to SR/CFG_Q/flag update is 2–3 CLK cycles.
- SI has the same 2-flop depth, so SI must be stable ≥3 CLK cycles before the SCLK1 rise and ≥1 cycle after it.
- CLK frequency ≥4× SCLK frequency. Each SCLK1/SCLK2/LAT high and low phase lasts ≥2 CLK cycles. The SCLK1 rise must precede the SCLK2 rise by ≥2 CLK cycles.
- CFG_VLD asserts in the cycle after the commit edge and lasts exactly 1 cycle. CFG_Q is valid from the same cycle.
- Throughput is one bit per SCLK1/SCLK2 pair, with no CLK-cycle dead time required between words beyond the LAT pulse.

## Test plan
- Reset: assert RST 2 cycles with all inputs high → every output 0. After release, one rise each on SCLK1/SCLK2/LAT is detected: BIT_CNT=1, then LEN_ERR=1.
- Nominal word: shift 16'hA5C3 MSB first (SCLK period 8 CLK), then LAT → CFG_Q=16'hA5C3, one-cycle CFG_VLD, BIT_CNT=0, no error flags. SO traces each shifted MSB, ending at 1.
- Short/long word: 15 bits then LAT → LEN_ERR=1, CFG_Q keeps its prior value. Then 20 bits then LAT → BIT_CNT saturates at 17, LAT rejected, CFG_Q unchanged.
- Phase error: SCLK2 pulse with no prior SCLK1 → PH_ERR=1, SR and BIT_CNT unchanged. The next proper 16-bit word still commits correctly.
- Overlap: SCLK1 and SCLK2 rising in the same CLK cycle → OV_ERR=1, no shift. Also check the case of SCLK2 and LAT rising in the same cycle on bit 16 → commit includes bit 16.
- Mid-word reset: after 9 bits assert RST 1 cycle → BIT_CNT=0, SR=0. A fresh 16'h0001 word then commits as 16'h0001.
